// File: rtl/sub_seq_nibble.sv
// Sequential A - B subtractor: one nibble per clock, LSB first, borrow chained between nibbles.
// Optional signed-overflow output ovf is built when SUB_SEQ_OVF_EN is defined.
module sub_seq_nibble #(
    parameter  int NIBBLES = 4,
    localparam int W       = 4 * NIBBLES
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] d,
    output logic         borrow,
`ifdef SUB_SEQ_OVF_EN
    output logic         ovf,
`endif
    output logic         busy
);

    localparam int KW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [W-1:0]  res_q, res_d;
    logic [KW-1:0] k_q, k_d;
    logic          bin_q, bin_d;
    logic [W-1:0]  d_q, d_d;
    logic          borrow_q, borrow_d;
    logic          out_valid_q, out_valid_d;
    logic          in_ready_q, in_ready_d;
    logic          busy_q, busy_d;
`ifdef SUB_SEQ_OVF_EN
    logic          ovf_q, ovf_d;
`endif

    logic [W-1:0]  a_sh, b_sh;
    logic [4:0]    t;

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        res_d       = res_q;
        k_d         = k_q;
        bin_d       = bin_q;
        d_d         = d_q;
        borrow_d    = borrow_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;
        busy_d      = busy_q;
`ifdef SUB_SEQ_OVF_EN
        ovf_d       = ovf_q;
`endif

        // Current nibble k of each operand, with the chained borrow-in.
        a_sh = a_q >> {k_q, 2'b00};
        b_sh = b_q >> {k_q, 2'b00};
        t    = {1'b0, a_sh[3:0]} - {1'b0, b_sh[3:0]} - {4'b0000, bin_q};

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d        = a;
                    b_d        = b;
                    res_d      = '0;
                    k_d        = '0;
                    bin_d      = 1'b0;
                    state_d    = RUN;
                    in_ready_d = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            RUN: begin
                res_d = res_q | (W'(t[3:0]) << {k_q, 2'b00});
                bin_d = t[4];
                k_d   = k_q + 1'b1;
                if (k_q == KW'(NIBBLES - 1)) begin
                    k_d     = '0;
                    state_d = DONE;
                    busy_d  = 1'b0;
                end
            end
            DONE: begin
                // First DONE cycle publishes the internal result; it then holds until accepted.
                if (!out_valid_q) begin
                    d_d         = res_q;
                    borrow_d    = bin_q;
`ifdef SUB_SEQ_OVF_EN
                    ovf_d       = (a_q[W-1] != b_q[W-1]) && (res_q[W-1] != a_q[W-1]);
`endif
                    out_valid_d = 1'b1;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                    in_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                in_ready_d  = 1'b1;
                busy_d      = 1'b0;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            k_q         <= '0;
            bin_q       <= 1'b0;
            d_q         <= '0;
            borrow_q    <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
`ifdef SUB_SEQ_OVF_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            res_q       <= res_d;
            k_q         <= k_d;
            bin_q       <= bin_d;
            d_q         <= d_d;
            borrow_q    <= borrow_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
`ifdef SUB_SEQ_OVF_EN
            ovf_q       <= ovf_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign d         = d_q;
    assign borrow    = borrow_q;
`ifdef SUB_SEQ_OVF_EN
    assign ovf       = ovf_q;
`endif

endmodule
